// File: rtl/sipo_rx_40_if.sv
// Output-side handshake bundle for sipo_rx_40: assembled word, valid/ready and parity status.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface sipo_rx_40_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              parity_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    output data_ready
  );
endinterface

// File: rtl/sipo_rx_40.sv
// Serial-in parallel-out receiver with a one-word output register and a sticky overrun flag.
// Optional even-parity frames are enabled by defining SIPO_RX_40_PARITY_EN.
module sipo_rx_40 #(
  parameter int WORD_W = 8
) (
  input  logic         clock_40,
  input  logic         reset,
  input  logic         enable,
  input  logic         serial_in,
  input  logic         frame_sync,
  input  logic         clear_overrun,
  output logic         overrun,
  sipo_rx_40_if.master bus
);

`ifdef SIPO_RX_40_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic {SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               ovr_q, ovr_d;
  logic               perr_q, perr_d;
  logic               wordDone;
  logic               framePerr;

  assign shifted  = {serial_in, shift_q[FRAME_W-1:1]};
  assign wordDone = enable && !frame_sync && (cnt_q == LAST_BIT);

  // The parity bit lands in the top of the shift register; even parity means the frame XOR is 0.
`ifdef SIPO_RX_40_PARITY_EN
  assign framePerr = ^shifted;
`else
  assign framePerr = 1'b0;
`endif

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (frame_sync) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (enable) begin
      shift_d = shifted;
      cnt_d   = wordDone ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ovr_d   = clear_overrun ? 1'b0 : ovr_q;
    case (state_q)
      SHIFT: begin
        if (wordDone) begin
          data_d  = shifted[WORD_W-1:0];
          perr_d  = framePerr;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.data_ready) begin
          if (wordDone) begin
            data_d = shifted[WORD_W-1:0];
            perr_d = framePerr;
          end else begin
            state_d = SHIFT;
          end
        end else if (wordDone) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clock_40) begin
    if (reset) begin
      state_q <= SHIFT;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = (state_q == HOLD);
  assign bus.parity_err = perr_q && (state_q == HOLD);
  assign overrun        = ovr_q;

endmodule

// File: doc/sipo_rx_40.md
SIPO_RX_40 -- requirements
Module: sipo_rx_40

Interface
REQ-001 Parameter WORD_W, default 8: number of data bits per word; legal range 2..16.
REQ-002 clock_40  input  1  40 MHz clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  bit strobe; serial_in SHALL be sampled only in cycles where enable=1.
REQ-005 serial_in  input  1  serial data, LSB first.
REQ-006 frame_sync  input  1  discards any partial word and restarts the bit count at 0.
REQ-007 data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
REQ-008 clear_overrun  input  1  clears the overrun flag.
REQ-009 data_out  output  WORD_W  assembled parallel word; bit 0 = first bit received.
REQ-010 data_valid  output  1  data_out holds an unaccepted word.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 parity_err  output  1  parity status of data_out, qualified by data_valid.

Function
REQ-013 The state machine SHALL have exactly two states, SHIFT and HOLD, describing the output register: SHIFT = empty, HOLD = data_valid=1.
REQ-014 Each cycle with enable=1 and frame_sync=0 SHALL shift serial_in into bit [WORD_W-1] of the shift register, shift the register right by one, and increment bit_cnt.
REQ-015 When the bit sampled completes a word (bit_cnt = WORD_W-1, or WORD_W in parity mode), bit_cnt SHALL wrap to 0 in the same cycle.
REQ-016 The completed word SHALL appear on data_out, with data_valid=1, in the cycle after the final bit is sampled (latency 1 clock).
REQ-017 Cycles with enable=0 SHALL hold the shift register and bit_cnt unchanged, so a word may span gaps.
REQ-018 frame_sync=1 SHALL clear bit_cnt and the shift register; frame_sync SHALL take priority over enable in the same cycle.
REQ-019 frame_sync SHALL NOT affect data_out, data_valid or overrun.
REQ-020 In HOLD, data_out SHALL stay stable until data_ready=1; the word is accepted in that cycle.
REQ-021 If a word is accepted and no word completes in the same cycle, the next cycle SHALL have data_valid=0 (return to SHIFT).
REQ-022 If a word completes in the same cycle as acceptance, the new word SHALL be loaded and data_valid SHALL stay 1.
REQ-023 If a word completes while in HOLD without acceptance, the new word SHALL be discarded, data_out SHALL be unchanged, and overrun SHALL be set the next cycle.
REQ-024 overrun SHALL stay 1 until clear_overrun=1 or reset.
REQ-025 If an overrun event and clear_overrun=1 occur in the same cycle, overrun SHALL end at 1 (set wins).
REQ-026 data_ready SHALL be ignored while data_valid=0.

Reset
REQ-027 While reset=1 the block SHALL drive data_out=0, data_valid=0, overrun=0 and parity_err=0, clear the shift register and bit_cnt, and enter SHIFT.
REQ-028 Reset SHALL take priority over all other inputs, including mid-word and in HOLD; a partial word SHALL be lost.
REQ-029 The first bit sampled after reset deasserts SHALL be bit 0 of a new word.

Configuration
REQ-030 With macro SIPO_RX_40_PARITY_EN defined, each frame SHALL be WORD_W+1 bits: WORD_W data bits, then one even-parity bit.
REQ-031 In parity mode, the parity bit SHALL NOT appear on data_out, and parity_err SHALL be 1 with the word if the XOR of the data bits and the parity bit is 1.
REQ-032 Without the macro, frames SHALL be WORD_W bits and parity_err SHALL be tied to 0; the port list SHALL be identical in both builds.

Verification
REQ-033 Reset, then enable=1 for 8 cycles with serial_in = 1,0,1,0,0,0,0,1, data_ready=1 -> data_out=8'h85 and data_valid=1 for exactly one cycle, appearing one cycle after the 8th bit.
REQ-034 Same bits as REQ-033 with enable=0 for 3 cycles after bit 4 -> data_out=8'h85; the shift register does not change during the gap.
REQ-035 Send 5 bits, then frame_sync=1 with enable=1, then 8 bits encoding 8'h3C -> data_out=8'h3C, no stale bits, overrun=0.
REQ-036 data_ready=0, send 8'hA5 then 8'h5A -> data_out stays 8'hA5 and overrun=1; then data_ready=1 for one cycle -> data_valid=0; then clear_overrun=1 -> overrun=0.
REQ-037 Hold word 8'h11 and pulse data_ready=1 in the same cycle word 8'h22 completes -> data_out=8'h22, data_valid stays 1, overrun=0.
REQ-038 With SIPO_RX_40_PARITY_EN defined, send 8'h07 with parity bit 1 -> parity_err=0; send 8'h07 with parity bit 0 -> parity_err=1. Assert reset mid-frame -> all outputs 0 the next cycle.
